// File: rtl/instrumented_adder_sequencer.sv
// Two-pass ring-oscillator measurement sequencer: pass 0 bypasses the adder, pass 1 includes it.
// Optional RUN watchdog enabled by defining SEQ_TIMEOUT_EN (adds parameter TIMEOUT_CYCLES).
module instrumented_adder_sequencer #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
`ifdef SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1 << 20
`endif
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] integration_time,
  input  logic             adder_done,
  input  logic [WIDTH-1:0] ring_count,
  output logic             adder_reset,
  output logic             stop_b,
  output logic             bypass_b,
  output logic             counter_enable,
  output logic             counter_load,
  output logic [WIDTH-1:0] integration_time_o,
  output logic             busy,
  output logic             result_valid,
  output logic             error,
  output logic [WIDTH-1:0] count_bypass,
  output logic [WIDTH-1:0] count_adder,
  output logic [WIDTH:0]   delta
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RST     = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_SETTLE  = 3'd4;
  localparam logic [2:0] S_CAPTURE = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  logic [2:0] state, state_next;
  logic       pass, pass_next;
  logic [7:0] cnt, cnt_next;
  logic       accept, reject, cap_bypass, cap_adder, timeout;

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] run_timer;

  // Cleared whenever the sequencer is outside RUN, so it reads 0 on the first RUN cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n)          run_timer <= '0;
    else if (state == S_RUN) run_timer <= run_timer + TW'(1);
    else                    run_timer <= '0;
  end
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_next = state;
    pass_next  = pass;
    cnt_next   = cnt;
    accept     = 1'b0;
    reject     = 1'b0;
    cap_bypass = 1'b0;
    cap_adder  = 1'b0;
    timeout    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (integration_time != '0) begin
            accept     = 1'b1;
            pass_next  = 1'b0;
            cnt_next   = '0;
            state_next = S_RST;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_RST: begin
        if (cnt == 8'd1) begin
          cnt_next   = '0;
          state_next = S_LOAD;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      S_LOAD: state_next = S_RUN;
      S_RUN: begin
        if (adder_done) begin
          cnt_next   = '0;
          state_next = S_SETTLE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (run_timer == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout    = 1'b1;
          state_next = S_IDLE;
        end
`endif
      end
      S_SETTLE: begin
        if (cnt == SETTLE_LAST) state_next = S_CAPTURE;
        else                    cnt_next   = cnt + 8'd1;
      end
      S_CAPTURE: begin
        if (!pass) begin
          cap_bypass = 1'b1;
          pass_next  = 1'b1;
          cnt_next   = '0;
          state_next = S_RST;
        end else begin
          cap_adder  = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    if (abort) begin
      state_next = S_IDLE;
      accept     = 1'b0;
      reject     = 1'b0;
      cap_bypass = 1'b0;
      cap_adder  = 1'b0;
      timeout    = 1'b0;
    end
  end

  // NOTE: control outputs are decoded from the next state and registered, so each output
  // changes on the same edge as the state and no input reaches an output combinationally.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state              <= S_IDLE;
      pass               <= 1'b0;
      cnt                <= '0;
      adder_reset        <= 1'b1;
      stop_b             <= 1'b0;
      bypass_b           <= 1'b0;
      counter_enable     <= 1'b0;
      counter_load       <= 1'b0;
      integration_time_o <= '0;
      busy               <= 1'b0;
      result_valid       <= 1'b0;
      error              <= 1'b0;
      count_bypass       <= '0;
      count_adder        <= '0;
      delta              <= '0;
    end else begin
      state          <= state_next;
      pass           <= pass_next;
      cnt            <= cnt_next;
      adder_reset    <= (state_next == S_IDLE) || (state_next == S_RST);
      stop_b         <= (state_next == S_RUN);
      counter_enable <= (state_next == S_RUN);
      counter_load   <= (state_next == S_LOAD);
      bypass_b       <= (state_next != S_IDLE) && pass_next;
      busy           <= (state_next != S_IDLE);

      if (accept) begin
        integration_time_o <= integration_time;
        result_valid       <= 1'b0;
        error              <= 1'b0;
      end
      if (reject || timeout) error <= 1'b1;
      if (abort) result_valid <= 1'b0;

      if (cap_bypass) count_bypass <= ring_count;
      // Delta uses the live ring count so it is valid on the same edge as result_valid.
      if (cap_adder) begin
        count_adder  <= ring_count;
        delta        <= {count_bypass[WIDTH-1], count_bypass} - {ring_count[WIDTH-1], ring_count};
        result_valid <= 1'b1;
      end
    end
  end

endmodule
